i2c_reg_seq_ctrl: RTL and testbench

//  Parametrised sequencer that turns single register RD/WR requests into WB command sequences.
//  The WB-side I2C byte controller executes those sequences as full I2C transactions.

---
 rtl/i2c_reg_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_i2c_reg_seq_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_seq_ctrl.sv
// rtl/i2c_reg_seq_ctrl.sv - register RD/WR request to WB I2C byte-controller command sequencer
module i2c_reg_seq_ctrl #(
   parameter logic [6:0] DEV_ADDR       = 7'h1A,
   parameter int         REG_ADDR_BYTES = 1,
   parameter int         DATA_BYTES     = 1,
   parameter int         POLL_TIMEOUT   = 1023
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic                        req_write_i,
   input  logic [8*REG_ADDR_BYTES-1:0] req_addr_i,
   input  logic [8*DATA_BYTES-1:0]     req_wdata_i,
   output logic                        rsp_valid_o,
   output logic [8*DATA_BYTES-1:0]     rsp_rdata_o,
   output logic [1:0]                  rsp_err_o,
   output logic                        busy_o,
   output logic                        wb_read_o,
   output logic                        wb_write_o,
   output logic [3:0]                  wb_address_o,
   output logic [7:0]                  wb_data_out_o,
   input  logic [7:0]                  wb_data_in_i,
   input  logic                        wb_data_in_valid_i,
   input  logic                        wb_done_i
);

   localparam int AW = 8 * REG_ADDR_BYTES;
   localparam int DW = 8 * DATA_BYTES;
   localparam int SW = AW + DW;
   localparam int PW = $clog2(POLL_TIMEOUT + 1);

   localparam logic [2:0]    LAST_SEQ  = 3'(REG_ADDR_BYTES + DATA_BYTES - 1);
   localparam logic [2:0]    LAST_ADDR = 3'(REG_ADDR_BYTES - 1);
   localparam logic [2:0]    LAST_DATA = 3'(DATA_BYTES - 1);
   localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_TIMEOUT);

   localparam logic [7:0] CMD_START = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;
   localparam logic [7:0] CMD_WRITE = 8'h04;
   localparam logic [7:0] CMD_STOP  = 8'h08;

   localparam logic [3:0] REG_STS  = 4'd0;
   localparam logic [3:0] REG_ADDR = 4'd2;
   localparam logic [3:0] REG_CMD  = 4'd3;
   localparam logic [3:0] REG_DATA = 4'd4;

   typedef enum logic [3:0] {
      IDLE, SET_ADDR, SET_DATA, SET_CMD, POLL, RD_DATA, WAIT, ABORT, RESP
   } state_t;

   typedef enum logic [1:0] {WK_WR, WK_STS, WK_DATA, WK_ABORT} wait_t;

   state_t          state_q, next_q;
   wait_t           wait_q;
   logic            write_q, stage_q, poll_b_q;
   logic [2:0]      byte_q;
   logic [PW-1:0]   poll_cnt_q;
   logic [SW-1:0]   seq_q;
   logic [DW-1:0]   rd_shift_q, rsp_rdata_q;
   logic [1:0]      rsp_err_q;
   logic            req_ready_q, rsp_valid_q, busy_q;
   logic            wb_read_q, wb_write_q;
   logic [3:0]      wb_address_q;
   logic [7:0]      wb_data_out_q;

   logic [7:0]      byte_d, cmd_d;
   logic [PW-1:0]   poll_cnt_d;
   logic [DW-1:0]   rd_shift_d;
   logic            sts_busy, sts_nack, poll_done;

   // Stage 0 writes address (and, for writes, data) bytes; stage 1 reads data bytes.
   always_comb begin
      byte_d = '0;
      for (int i = 0; i < SW / 8; i++) begin
         if (byte_q == 3'(i)) byte_d = seq_q[SW-8-8*i +: 8];
      end
      if (!stage_q) begin
         cmd_d = CMD_WRITE;
         if (byte_q == 3'd0) cmd_d = cmd_d | CMD_START;
         if (write_q && byte_q == LAST_SEQ) cmd_d = cmd_d | CMD_STOP;
      end else begin
         cmd_d = CMD_READ;
         if (byte_q == 3'd0) cmd_d = cmd_d | CMD_START;
         if (byte_q == LAST_DATA) cmd_d = cmd_d | CMD_STOP;
      end
      sts_busy   = wb_data_in_i[0];
      sts_nack   = wb_data_in_i[1];
      poll_done  = poll_b_q ? !sts_busy : (!sts_busy && sts_nack);
      poll_cnt_d = poll_cnt_q + PW'(1);
      rd_shift_d = (rd_shift_q << 8) | DW'(wb_data_in_i);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         next_q        <= IDLE;
         wait_q        <= WK_WR;
         write_q       <= 1'b0;
         stage_q       <= 1'b0;
         poll_b_q      <= 1'b0;
         byte_q        <= '0;
         poll_cnt_q    <= '0;
         seq_q         <= '0;
         rd_shift_q    <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= '0;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         wb_read_q     <= 1'b0;
         wb_write_q    <= 1'b0;
         wb_address_q  <= '0;
         wb_data_out_q <= '0;
      end else begin
         wb_read_q   <= 1'b0;
         wb_write_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid_i && req_ready_q) begin
                  write_q     <= req_write_i;
                  seq_q       <= {req_addr_i, req_wdata_i};
                  stage_q     <= 1'b0;
                  byte_q      <= '0;
                  rd_shift_q  <= '0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 2'b00;
                  busy_q      <= 1'b1;
                  req_ready_q <= 1'b0;
                  state_q     <= SET_ADDR;
               end
            end
            SET_ADDR: begin
               wb_write_q    <= 1'b1;
               wb_address_q  <= REG_ADDR;
               wb_data_out_q <= {DEV_ADDR, stage_q};
               wait_q        <= WK_WR;
               next_q        <= stage_q ? SET_CMD : SET_DATA;
               state_q       <= WAIT;
            end
            SET_DATA: begin
               wb_write_q    <= 1'b1;
               wb_address_q  <= REG_DATA;
               wb_data_out_q <= byte_d;
               wait_q        <= WK_WR;
               next_q        <= SET_CMD;
               state_q       <= WAIT;
            end
            SET_CMD: begin
               wb_write_q    <= 1'b1;
               wb_address_q  <= REG_CMD;
               wb_data_out_q <= cmd_d;
               wait_q        <= WK_WR;
               next_q        <= POLL;
               poll_cnt_q    <= '0;
               poll_b_q      <= 1'b0;
               state_q       <= WAIT;
            end
            POLL: begin
               wb_read_q    <= 1'b1;
               wb_address_q <= REG_STS;
               wait_q       <= WK_STS;
               state_q      <= WAIT;
            end
            RD_DATA: begin
               wb_read_q    <= 1'b1;
               wb_address_q <= REG_DATA;
               wait_q       <= WK_DATA;
               state_q      <= WAIT;
            end
            ABORT: begin
               wb_write_q    <= 1'b1;
               wb_address_q  <= REG_CMD;
               wb_data_out_q <= CMD_STOP;
               wait_q        <= WK_ABORT;
               state_q       <= WAIT;
            end
            WAIT: begin
               // A done that coincides with our own strobe belongs to an earlier op.
               if (!wb_read_q && !wb_write_q && wb_done_i) begin
                  case (wait_q)
                     WK_WR: state_q <= next_q;
                     WK_ABORT: begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                     end
                     WK_STS: begin
                        if (wb_data_in_valid_i) begin
                           poll_cnt_q <= poll_cnt_d;
                           if (sts_busy) poll_b_q <= 1'b1;
                           if (poll_done) begin
                              if (sts_nack) begin
                                 rsp_err_q <= 2'b01;
                                 state_q   <= ABORT;
                              end else if (stage_q) begin
                                 state_q <= RD_DATA;
                              end else if (write_q && byte_q == LAST_SEQ) begin
                                 rsp_valid_q <= 1'b1;
                                 state_q     <= RESP;
                              end else if (!write_q && byte_q == LAST_ADDR) begin
                                 stage_q <= 1'b1;
                                 byte_q  <= '0;
                                 state_q <= SET_ADDR;
                              end else begin
                                 byte_q  <= byte_q + 3'd1;
                                 state_q <= SET_DATA;
                              end
                           end else if (poll_cnt_d >= POLL_MAX) begin
                              rsp_err_q <= 2'b10;
                              state_q   <= ABORT;
                           end else begin
                              state_q <= POLL;
                           end
                        end
                     end
                     WK_DATA: begin
                        if (wb_data_in_valid_i) begin
                           rd_shift_q <= rd_shift_d;
                           if (byte_q == LAST_DATA) begin
                              rsp_rdata_q <= rd_shift_d;
                              rsp_valid_q <= 1'b1;
                              state_q     <= RESP;
                           end else begin
                              byte_q  <= byte_q + 3'd1;
                              state_q <= SET_CMD;
                           end
                        end
                     end
                     default: state_q <= IDLE;
                  endcase
               end
            end
            RESP: begin
               busy_q      <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o   = req_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;
   assign busy_o        = busy_q;
   assign wb_read_o     = wb_read_q;
   assign wb_write_o    = wb_write_q;
   assign wb_address_o  = wb_address_q;
   assign wb_data_out_o = wb_data_out_q;

endmodule

// File: tb/tb_i2c_reg_seq_ctrl.sv
// tb/tb_i2c_reg_seq_ctrl.sv - scoreboard bench for i2c_reg_seq_ctrl with a reactive WB I2C controller model
module tb_i2c_reg_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic        req_valid[2], req_write[2], req_ready[2], rsp_valid[2], busy[2];
   logic [15:0] req_addr[2], req_wdata[2];
   logic [1:0]  rsp_err[2];
   logic        wb_read[2], wb_write[2], wb_data_in_valid[2], wb_done[2];
   logic [3:0]  wb_address[2];
   logic [7:0]  wb_data_out[2], wb_data_in[2];
   logic [7:0]  rsp_rdata0;
   logic [15:0] rsp_rdata1;

   int errors = 0;
   int checks = 0;

   // Scoreboard entries: {instance, is_write, wb_address, data}
   logic [13:0] exp_q[$];
   logic [13:0] obs_q[$];
   logic [17:0] exp_rsp[$];

   int          rsp_cnt[2]   = '{0, 0};
   int          sts_reads[2] = '{0, 0};
   int          sts_idx[2]   = '{0, 0};
   int          rd_idx[2]    = '{0, 0};
   int          both_cnt     = 0;
   int          sts_mode[2];
   logic [7:0]  rd_val[2];
   logic [1:0]  last_err[2];
   logic [15:0] last_rdata[2];
   logic [7:0]  rdv;

   i2c_reg_seq_ctrl dut0 (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
      .req_addr_i(req_addr[0][7:0]), .req_wdata_i(req_wdata[0][7:0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err[0]),
      .busy_o(busy[0]), .wb_read_o(wb_read[0]), .wb_write_o(wb_write[0]),
      .wb_address_o(wb_address[0]), .wb_data_out_o(wb_data_out[0]),
      .wb_data_in_i(wb_data_in[0]), .wb_data_in_valid_i(wb_data_in_valid[0]), .wb_done_i(wb_done[0])
   );

   i2c_reg_seq_ctrl #(.REG_ADDR_BYTES(2), .DATA_BYTES(2), .POLL_TIMEOUT(8)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
      .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err[1]),
      .busy_o(busy[1]), .wb_read_o(wb_read[1]), .wb_write_o(wb_write[1]),
      .wb_address_o(wb_address[1]), .wb_data_out_o(wb_data_out[1]),
      .wb_data_in_i(wb_data_in[1]), .wb_data_in_valid_i(wb_data_in_valid[1]), .wb_done_i(wb_done[1])
   );

   // WB controller model: answers every strobe one cycle later; STS pattern chosen by sts_mode
   // (0: busy then idle, 1: busy then NACK, 2: stuck busy).
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         wb_done[g]          <= 1'b0;
         wb_data_in_valid[g] <= 1'b0;
         if (wb_read[g] && wb_write[g]) both_cnt++;
         if (wb_write[g]) begin
            obs_q.push_back({1'(g), 1'b1, wb_address[g], wb_data_out[g]});
            if (wb_address[g] == 4'd3) sts_idx[g] = 0;
            if (wb_address[g] == 4'd2) rd_idx[g] = 0;
            wb_done[g] <= 1'b1;
         end else if (wb_read[g]) begin
            if (wb_address[g] == 4'd0) begin
               if (sts_idx[g] == 0) rdv = 8'h01;
               else if (sts_mode[g] == 0) rdv = 8'h00;
               else if (sts_mode[g] == 1) rdv = 8'h02;
               else rdv = 8'h01;
               sts_reads[g]++;
               sts_idx[g]++;
            end else begin
               rdv = rd_val[g] + 8'(17 * rd_idx[g]);
               rd_idx[g]++;
               obs_q.push_back({1'(g), 1'b0, wb_address[g], rdv});
            end
            wb_data_in[g]       <= rdv;
            wb_data_in_valid[g] <= 1'b1;
            wb_done[g]          <= 1'b1;
         end
         if (rsp_valid[g]) begin
            rsp_cnt[g]++;
            last_err[g]   = rsp_err[g];
            last_rdata[g] = (g == 0) ? {8'h00, rsp_rdata0} : rsp_rdata1;
         end
      end
   end

   task automatic push_op(input int g, input logic wr, input logic [3:0] a, input logic [7:0] d);
      exp_q.push_back({1'(g), wr, a, d});
   endtask

   task automatic issue(input int g, input logic wr, input logic [15:0] a, input logic [15:0] d);
      int n = 0;
      @(negedge clk);
      while (!req_ready[g] && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready[g] !== 1'b1) begin
         errors++;
         $display("FAIL req_ready dut%0d: got %b want 1", g, req_ready[g]);
      end
      req_valid[g] = 1'b1;
      req_write[g] = wr;
      req_addr[g]  = a;
      req_wdata[g] = d;
      @(negedge clk);
      req_valid[g] = 1'b0;
      req_write[g] = 1'($urandom);
      req_addr[g]  = 16'($urandom);
      req_wdata[g] = 16'($urandom);
      checks++;
      if (busy[g] !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_accept dut%0d: got %b want 1", g, busy[g]);
      end
   endtask

   task automatic wait_rsp(input int g, input int c0, input string name);
      int n = 0;
      logic [17:0] e;
      logic [13:0] eo, oo;
      while (rsp_cnt[g] == c0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      e = exp_rsp.pop_front();
      checks++;
      if (rsp_cnt[g] == c0) begin
         errors++;
         $display("FAIL %s rsp_timeout: got no rsp_valid, want one within 3000 cycles", name);
      end else if ({last_err[g], last_rdata[g]} !== e) begin
         errors++;
         $display("FAIL %s rsp: got err=%b rdata=%h want err=%b rdata=%h",
                  name, last_err[g], last_rdata[g], e[17:16], e[15:0]);
      end
      checks++;
      if ({busy[g], req_ready[g]} !== 2'b01) begin
         errors++;
         $display("FAIL %s busy/ready_after_rsp: got %b%b want 01", name, busy[g], req_ready[g]);
      end
      while (exp_q.size() > 0) begin
         eo = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL %s wb_op: got none want wr=%b a=%h d=%h", name, eo[12], eo[11:8], eo[7:0]);
         end else begin
            oo = obs_q.pop_front();
            if (oo !== eo) begin
               errors++;
               $display("FAIL %s wb_op: got wr=%b a=%h d=%h want wr=%b a=%h d=%h",
                        name, oo[12], oo[11:8], oo[7:0], eo[12], eo[11:8], eo[7:0]);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL %s extra_wb_ops: got %0d want 0", name, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready[0], busy[0], rsp_valid[0], wb_read[0], wb_write[0], wb_address[0],
           wb_data_out[0], rsp_err[0], rsp_rdata0} !== 27'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b busy=%b rv=%b rd=%b wr=%b a=%h d=%h err=%b rdata=%h want all 0",
                  req_ready[0], busy[0], rsp_valid[0], wb_read[0], wb_write[0], wb_address[0],
                  wb_data_out[0], rsp_err[0], rsp_rdata0);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_ready[0], busy[0], req_ready[1]} !== 3'b101) begin
         errors++;
         $display("FAIL idle_after_reset: got rdy0=%b busy0=%b rdy1=%b want 1 0 1",
                  req_ready[0], busy[0], req_ready[1]);
      end
   endtask

   task automatic test_write();
      int c0 = rsp_cnt[0];
      int s0 = sts_reads[0];
      push_op(0, 1, 2, 8'h34); push_op(0, 1, 4, 8'h07); push_op(0, 1, 3, 8'h05);
      push_op(0, 1, 4, 8'h5A); push_op(0, 1, 3, 8'h0C);
      exp_rsp.push_back({2'b00, 16'h0000});
      issue(0, 1'b1, 16'h0007, 16'h005A);
      wait_rsp(0, c0, "write");
      checks++;
      if (sts_reads[0] - s0 != 4) begin
         errors++;
         $display("FAIL write sts_reads: got %0d want 4", sts_reads[0] - s0);
      end
   endtask

   task automatic test_read();
      int c0 = rsp_cnt[0];
      rd_val[0] = 8'hA5;
      push_op(0, 1, 2, 8'h34); push_op(0, 1, 4, 8'h07); push_op(0, 1, 3, 8'h05);
      push_op(0, 1, 2, 8'h35); push_op(0, 1, 3, 8'h0B); push_op(0, 0, 4, 8'hA5);
      exp_rsp.push_back({2'b00, 16'h00A5});
      issue(0, 1'b0, 16'h0007, 16'h0000);
      wait_rsp(0, c0, "read");
   endtask

   task automatic test_nack();
      int c0 = rsp_cnt[0];
      sts_mode[0] = 1;
      push_op(0, 1, 2, 8'h34); push_op(0, 1, 4, 8'h07); push_op(0, 1, 3, 8'h05);
      push_op(0, 1, 3, 8'h08);
      exp_rsp.push_back({2'b01, 16'h0000});
      issue(0, 1'b1, 16'h0007, 16'h005A);
      wait_rsp(0, c0, "nack");
      sts_mode[0] = 0;
   endtask

   task automatic test_timeout();
      int c0 = rsp_cnt[1];
      int s0 = sts_reads[1];
      sts_mode[1] = 2;
      push_op(1, 1, 2, 8'h34); push_op(1, 1, 4, 8'h12); push_op(1, 1, 3, 8'h05);
      push_op(1, 1, 3, 8'h08);
      exp_rsp.push_back({2'b10, 16'h0000});
      issue(1, 1'b1, 16'h1234, 16'hBEEF);
      wait_rsp(1, c0, "timeout");
      checks++;
      if (sts_reads[1] - s0 != 8) begin
         errors++;
         $display("FAIL timeout sts_reads: got %0d want 8", sts_reads[1] - s0);
      end
      sts_mode[1] = 0;
   endtask

   task automatic test_wide();
      int c0 = rsp_cnt[1];
      push_op(1, 1, 2, 8'h34);
      push_op(1, 1, 4, 8'h12); push_op(1, 1, 3, 8'h05);
      push_op(1, 1, 4, 8'h34); push_op(1, 1, 3, 8'h04);
      push_op(1, 1, 4, 8'hBE); push_op(1, 1, 3, 8'h04);
      push_op(1, 1, 4, 8'hEF); push_op(1, 1, 3, 8'h0C);
      exp_rsp.push_back({2'b00, 16'h0000});
      issue(1, 1'b1, 16'h1234, 16'hBEEF);
      wait_rsp(1, c0, "wide_write");
      c0 = rsp_cnt[1];
      rd_val[1] = 8'hC3;
      push_op(1, 1, 2, 8'h34);
      push_op(1, 1, 4, 8'h00); push_op(1, 1, 3, 8'h05);
      push_op(1, 1, 4, 8'hAB); push_op(1, 1, 3, 8'h04);
      push_op(1, 1, 2, 8'h35);
      push_op(1, 1, 3, 8'h03); push_op(1, 0, 4, 8'hC3);
      push_op(1, 1, 3, 8'h0A); push_op(1, 0, 4, 8'hD4);
      exp_rsp.push_back({2'b00, 16'hC3D4});
      issue(1, 1'b0, 16'h00AB, 16'h0000);
      wait_rsp(1, c0, "wide_read");
   endtask

   task automatic test_reset_mid();
      int c0 = rsp_cnt[0];
      int s0 = sts_reads[0];
      int n = 0;
      issue(0, 1'b1, 16'h0007, 16'h005A);
      while (sts_reads[0] == s0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sts_reads[0] == s0) begin
         errors++;
         $display("FAIL reset_mid poll_reached: got no STS read, want one");
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({wb_read[0], wb_write[0], busy[0], rsp_valid[0], req_ready[0]} !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid outputs: got rd=%b wr=%b busy=%b rv=%b rdy=%b want 0",
                  wb_read[0], wb_write[0], busy[0], rsp_valid[0], req_ready[0]);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (rsp_cnt[0] != c0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid no_rsp: got rsp_count=%0d busy=%b want %0d 0", rsp_cnt[0], busy[0], c0);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      test_write();
      test_read();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running want finish");
      $fatal(1);
   end

   initial begin
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b0;
         req_write[g] = 1'b0;
         req_addr[g]  = 16'h0;
         req_wdata[g] = 16'h0;
         sts_mode[g]  = 0;
         rd_val[g]    = 8'h00;
      end
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_timeout();
      test_wide();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL strobe_exclusive: got %0d cycles with read and write both high want 0", both_cnt);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
